// File: rtl/float_mult_seq.sv
// Sequential IEEE-754 single multiplier: 24-step shift-add mantissa product over valid/ready.
// Define FLOAT_MUL_RNE_EN for round-to-nearest-even; default build truncates toward zero.
module float_mult_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] result,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

  state_t             state, state_nx;
  logic [23:0]        ma, mb;
  logic               sign;
  logic signed [9:0]  exp_r;
  logic [4:0]         cnt;
  logic [47:0]        acc;
  logic [31:0]        res_r;

  logic        a_zero, a_inf, a_nan, b_zero, b_inf, b_nan, special;
  logic [31:0] spec_res;

  // Denormal operands (exp==0) are flushed to zero before classification.
  always_comb begin
    a_zero   = (A[30:23] == 8'h00);
    a_inf    = (A[30:23] == 8'hFF) && (A[22:0] == '0);
    a_nan    = (A[30:23] == 8'hFF) && (A[22:0] != '0);
    b_zero   = (B[30:23] == 8'h00);
    b_inf    = (B[30:23] == 8'hFF) && (B[22:0] == '0);
    b_nan    = (B[30:23] == 8'hFF) && (B[22:0] != '0);
    special  = a_zero | a_inf | a_nan | b_zero | b_inf | b_nan;
    spec_res = {A[31] ^ B[31], 31'h0};
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf))
      spec_res = 32'h7FC00000;
    else if (a_inf || b_inf)
      spec_res = {A[31] ^ B[31], 8'hFF, 23'h0};
  end

  logic [22:0]       frac_t, frac_f;
  logic signed [9:0] e_t, e_f;
  logic [31:0]       norm_res;
`ifdef FLOAT_MUL_RNE_EN
  logic              guard, sticky;
  logic [23:0]       rnd;
`endif

  always_comb begin
    if (acc[47]) begin
      frac_t = acc[46:24];
      e_t    = exp_r + 10'sd1;
    end else begin
      frac_t = acc[45:23];
      e_t    = exp_r;
    end
`ifdef FLOAT_MUL_RNE_EN
    guard  = acc[47] ? acc[23] : acc[22];
    sticky = acc[47] ? (|acc[22:0]) : (|acc[21:0]);
    rnd    = {1'b0, frac_t} + {23'h0, guard & (sticky | frac_t[0])};
    // A carry out leaves frac at zero, which is exactly the renormalised 1.0.
    frac_f = rnd[22:0];
    e_f    = rnd[23] ? (e_t + 10'sd1) : e_t;
`else
    frac_f = frac_t;
    e_f    = e_t;
`endif
    if (e_f >= 10'sd255)
      norm_res = {sign, 8'hFF, 23'h0};
    else if (e_f <= 10'sd0)
      norm_res = {sign, 31'h0};
    else
      norm_res = {sign, e_f[7:0], frac_f};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (in_valid) state_nx = special ? DONE : MUL;
      MUL:  if (cnt == 5'd23) state_nx = NORM;
      NORM: state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    result    = res_r;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma    <= '0;
      mb    <= '0;
      sign  <= 1'b0;
      exp_r <= '0;
      cnt   <= '0;
      acc   <= '0;
      res_r <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sign  <= A[31] ^ B[31];
          ma    <= {1'b1, A[22:0]};
          mb    <= {1'b1, B[22:0]};
          exp_r <= $signed({2'b00, A[30:23]}) + $signed({2'b00, B[30:23]}) - 10'sd127;
          acc   <= '0;
          cnt   <= '0;
          if (special) res_r <= spec_res;
        end
        MUL: begin
          if (mb[cnt]) acc <= acc + ({24'h0, ma} << cnt);
          cnt <= (cnt == 5'd23) ? 5'd0 : cnt + 5'd1;
        end
        NORM: res_r <= norm_res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_float_mult_seq.sv
// Self-checking bench for float_mult_seq: directed cases plus random operands vs a reference model.
module tb_float_mult_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic [31:0] result;
  logic        out_valid;

  int errors = 0;
  int checks = 0;

  float_mult_seq dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .in_valid(in_valid),
    .in_ready(in_ready), .result(result), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Reference: exact integer product, then rounding by remainder comparison.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic s;
    int ea, eb, e, sh;
    longint unsigned p, m, rem, half;
    bit za, zb, ia, ib, na, nb;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    za = (ea == 0);   zb = (eb == 0);
    ia = (ea == 255) && (a[22:0] == 0);  ib = (eb == 255) && (b[22:0] == 0);
    na = (ea == 255) && (a[22:0] != 0);  nb = (eb == 255) && (b[22:0] != 0);
    if (na || nb || (ia && zb) || (za && ib)) return 32'h7FC00000;
    if (ia || ib) return {s, 8'hFF, 23'h0};
    if (za || zb) return {s, 31'h0};
    p = (longint'(1 << 23) + longint'(a[22:0])) * (longint'(1 << 23) + longint'(b[22:0]));
    e = ea + eb - 127;
    if (p >= (64'd1 << 47)) begin sh = 24; e = e + 1; end
    else sh = 23;
    m    = p >> sh;
    rem  = p & ((64'd1 << sh) - 1);
    half = 64'd1 << (sh - 1);
`ifdef FLOAT_MUL_RNE_EN
    if (rem > half || (rem == half && m[0])) m = m + 1;
    if (m == (64'd1 << 24)) begin m = m >> 1; e = e + 1; end
`else
    if (rem > half) m = m; // truncation ignores the remainder
`endif
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0)   return {s, 31'h0};
    return {s, e[7:0], m[22:0]};
  endfunction

  // Issue one op from IDLE; lat counts edges after the accept edge until out_valid.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit consume,
                        output logic [31:0] res, output int lat);
    A = a; B = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result;
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL timeout: out_valid=%b required 1 within 60 cycles", out_valid);
    end
    if (consume) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 00000000", result); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [31:0] r; int lat;
    logic [31:0] want_rnd;
    run_op(32'h3FC00000, 32'h40000000, 1'b1, r, lat);
    checks++; if (r !== 32'h40400000) begin errors++; $display("FAIL basic_result: got %h want 40400000", r); end
    checks++; if (lat !== 25) begin errors++; $display("FAIL basic_latency: got %0d want 25", lat); end
    run_op(32'hC0CCCCCD, 32'hBF000000, 1'b1, r, lat);
    checks++; if (r !== 32'h404CCCCD) begin errors++; $display("FAIL signs_result: got %h want 404CCCCD", r); end
`ifdef FLOAT_MUL_RNE_EN
    want_rnd = 32'h40100002;
`else
    want_rnd = 32'h40100001;
`endif
    run_op(32'h3FC00001, 32'h3FC00001, 1'b1, r, lat);
    checks++; if (r !== want_rnd) begin errors++; $display("FAIL rounding_result: got %h want %h", r, want_rnd); end
  endtask

  task automatic test_specials();
    logic [31:0] r; int lat;
    run_op(32'h7F800000, 32'h00000000, 1'b1, r, lat);
    checks++; if (r !== 32'h7FC00000) begin errors++; $display("FAIL inf_x_zero: got %h want 7FC00000", r); end
    checks++; if (lat !== 0) begin errors++; $display("FAIL special_latency: got %0d want 0", lat); end
    run_op(32'h7F000000, 32'h7F000000, 1'b1, r, lat);
    checks++; if (r !== 32'h7F800000) begin errors++; $display("FAIL overflow: got %h want 7F800000", r); end
    run_op(32'h00800000, 32'h00800000, 1'b1, r, lat);
    checks++; if (r !== 32'h00000000) begin errors++; $display("FAIL underflow: got %h want 00000000", r); end
    run_op(32'hFF800000, 32'h40000000, 1'b1, r, lat);
    checks++; if (r !== 32'hFF800000) begin errors++; $display("FAIL neg_inf: got %h want FF800000", r); end
    run_op(32'h80000000, 32'h3F800000, 1'b1, r, lat);
    checks++; if (r !== 32'h80000000) begin errors++; $display("FAIL neg_zero: got %h want 80000000", r); end
  endtask

  task automatic test_random();
    logic [31:0] a, b, r, want; int lat, want_lat;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        a = $urandom; b = $urandom;
      end else begin
        a = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
        b = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
      end
      want = ref_mul(a, b);
      want_lat = (a[30:23] == 8'h00 || a[30:23] == 8'hFF ||
                  b[30:23] == 8'h00 || b[30:23] == 8'hFF) ? 0 : 25;
      run_op(a, b, 1'b1, r, lat);
      checks++; if (r !== want) begin errors++; $display("FAIL random_result %h*%h: got %h want %h", a, b, r, want); end
      checks++; if (lat !== want_lat) begin errors++; $display("FAIL random_latency %h*%h: got %0d want %0d", a, b, lat, want_lat); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r; int lat; int bad;
    run_op(32'h3FC00000, 32'h40000000, 1'b0, r, lat);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      A = 32'h40400000; B = 32'h40400000; in_valid = 1'b1;
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || result !== 32'h40400000 || in_ready !== 1'b0) bad++;
    end
    in_valid = 1'b0;
    checks++; if (bad !== 0) begin errors++; $display("FAIL backpressure_hold: got %0d unstable cycles want 0", bad); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL transfer_out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL transfer_in_ready: got %b want 1", in_ready); end
    run_op(32'hC0CCCCCD, 32'hBF000000, 1'b1, r, lat);
    checks++; if (r !== 32'h404CCCCD) begin errors++; $display("FAIL back_to_back_result: got %h want 404CCCCD", r); end
    checks++; if (lat !== 25) begin errors++; $display("FAIL back_to_back_latency: got %0d want 25", lat); end
  endtask

  task automatic test_early_out_ready();
    int lat;
    out_ready = 1'b1;
    A = 32'h40000000; B = 32'h40400000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 60) begin @(posedge clk); #1; lat++; end
    checks++; if (lat !== 25) begin errors++; $display("FAIL early_ready_latency: got %0d want 25", lat); end
    checks++; if (result !== 32'h40C00000) begin errors++; $display("FAIL early_ready_result: got %h want 40C00000", result); end
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL early_ready_transfer: got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r; int lat; int seen;
    A = 32'h3FC00000; B = 32'h40000000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midreset_in_ready: got %b want 1", in_ready); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL midreset_result: got %h want 00000000", result); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midreset_no_pulse: got %0d valid cycles want 0", seen); end
    run_op(32'h3FC00000, 32'h40000000, 1'b1, r, lat);
    checks++; if (r !== 32'h40400000) begin errors++; $display("FAIL after_reset_result: got %h want 40400000", r); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_specials();
    test_back_to_back();
    test_early_out_ready();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
